// File: rtl/box_sprite_engine.sv
// Box sprite engine: draws a movable head box and a static target box into the
// vga_adapter write port, one pixel per clock, and moves the head once per frame tick.
module box_sprite_engine #(
  parameter int         XSCREEN   = 160,
  parameter int         YSCREEN   = 120,
  parameter int         XDIM      = 10,
  parameter int         YDIM      = 10,
  parameter int         STEP      = 1,
  parameter int         EDGE_MODE = 0,
  parameter int         X0        = 39,
  parameter int         Y0        = 59,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       init,
  input  logic       start,
  input  logic       tick,
  input  logic       dir_valid,
  input  logic [1:0] dir,
  input  logic       tgt_load,
  input  logic [7:0] tgt_x,
  input  logic [6:0] tgt_y,
  input  logic [2:0] head_colour,
  input  logic [2:0] tgt_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       hit,
  output logic [7:0] head_x,
  output logic [6:0] head_y
);
  typedef enum logic [2:0] {IDLE, DRAW_HEAD, DRAW_TGT, WAIT, ERASE, MOVE} state_t;

  localparam bit         WRAP    = (EDGE_MODE != 0);
  localparam logic [8:0] XLIM    = 9'(XSCREEN - XDIM);
  localparam logic [7:0] YLIM    = 8'(YSCREEN - YDIM);
  localparam logic [8:0] XSTEP   = 9'(STEP);
  localparam logic [7:0] YSTEP   = 8'(STEP);
  localparam logic [7:0] XC_LAST = 8'(XDIM - 1);
  localparam logic [6:0] YC_LAST = 7'(YDIM - 1);

  state_t     state_q, state_d;
  logic [7:0] xc_q, xc_d;
  logic [6:0] yc_q, yc_d;
  logic [7:0] hx_q, hx_d;
  logic [6:0] hy_q, hy_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] ty_q, ty_d;
  logic [1:0] dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       hit_q, hit_d;

  logic [8:0] nx, dx, hx9, tx9;
  logic [7:0] ny, dy, hy8, ty8;
  logic       scan, last_px, overlap;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] colour;

  assign scan    = (state_q == DRAW_HEAD) || (state_q == DRAW_TGT) || (state_q == ERASE);
  assign last_px = (xc_q == XC_LAST) && (yc_q == YC_LAST);
  assign hx9     = {1'b0, hx_q};
  assign hy8     = {1'b0, hy_q};
  assign tx9     = {1'b0, tx_q};
  assign ty8     = {1'b0, ty_q};

  // Candidate head position for the MOVE cycle; one spare bit per axis keeps sums exact.
  always_comb begin
    nx = hx9;
    ny = hy8;
    if (moving_q) begin
      unique case (dir_q)
        2'b00: nx = (hx9 + XSTEP > XLIM) ? (WRAP ? 9'd0 : XLIM) : hx9 + XSTEP;
        2'b11: nx = (hx9 < XSTEP)        ? (WRAP ? XLIM : 9'd0) : hx9 - XSTEP;
        2'b01: ny = (hy8 + YSTEP > YLIM) ? (WRAP ? 8'd0 : YLIM) : hy8 + YSTEP;
        2'b10: ny = (hy8 < YSTEP)        ? (WRAP ? YLIM : 8'd0) : hy8 - YSTEP;
      endcase
    end
  end

  assign dx      = (nx >= tx9) ? nx - tx9 : tx9 - nx;
  assign dy      = (ny >= ty8) ? ny - ty8 : ty8 - ny;
  assign overlap = (dx < 9'(XDIM)) && (dy < 8'(YDIM));

  always_comb begin
    state_d  = state_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    dir_d    = dir_valid ? dir : dir_q;
    moving_d = moving_q | dir_valid;
    hit_d    = 1'b0;
    // Raster counters wrap to zero on the last pixel, so every scan state starts clean.
    if (scan) begin
      if (xc_q == XC_LAST) begin
        xc_d = 8'd0;
        yc_d = last_px ? 7'd0 : yc_q + 7'd1;
      end else begin
        xc_d = xc_q + 8'd1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (init) begin
          hx_d = 8'(X0);
          hy_d = 7'(Y0);
        end
        if (tgt_load) begin
          tx_d = tgt_x;
          ty_d = tgt_y;
        end
        if (start) state_d = DRAW_HEAD;
      end
      DRAW_HEAD: if (last_px) state_d = DRAW_TGT;
      DRAW_TGT:  if (last_px) state_d = WAIT;
      WAIT: begin
        if (tgt_load) begin
          tx_d = tgt_x;
          ty_d = tgt_y;
        end
        if (tick) state_d = ERASE;
      end
      ERASE: if (last_px) state_d = MOVE;
      MOVE: begin
        hx_d    = nx[7:0];
        hy_d    = ny[6:0];
        hit_d   = overlap;
        state_d = DRAW_HEAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      xc_q     <= 8'd0;
      yc_q     <= 7'd0;
      hx_q     <= 8'd0;
      hy_q     <= 7'd0;
      tx_q     <= 8'd80;
      ty_q     <= 7'd60;
      dir_q    <= 2'b00;
      moving_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    base_x = hx_q;
    base_y = hy_q;
    colour = head_colour;
    if (state_q == DRAW_TGT) begin
      base_x = tx_q;
      base_y = ty_q;
      colour = tgt_colour;
    end else if (state_q == ERASE) begin
      colour = BG_COLOUR;
    end
  end

  assign plot       = scan;
  assign vga_x      = scan ? base_x + xc_q : 8'd0;
  assign vga_y      = scan ? base_y + yc_q : 7'd0;
  assign vga_colour = scan ? colour : 3'd0;
  assign busy       = (state_q != IDLE) && (state_q != WAIT);
  assign hit        = hit_q;
  assign head_x     = hx_q;
  assign head_y     = hy_q;
endmodule

// File: doc/box_sprite_engine.md
# box_sprite_engine

Parametrised pixel-plotting engine for the 160x120 snake display. It owns one movable box (the snake head) and one static target box (the apple), and drives the `vga_adapter` write port one pixel per clock. It runs a draw / wait / erase / move cycle with a registered direction, selectable edge behaviour, and a one-cycle hit pulse when the moved box overlaps the target. It sits between the key/direction decoder and `vga_adapter`.

## Interface
Parameters:
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- XDIM, 10, box width (1..XSCREEN)
- YDIM, 10, box height (1..YSCREEN)
- STEP, 1, pixels moved per MOVE (1..XDIM)
- EDGE_MODE, 0, 0 = stop at edge (saturate), 1 = wrap around
- X0, 39, head x loaded by init
- Y0, 59, head y loaded by init
- BG_COLOUR, 3'b000, erase colour

Ports:
- CLOCK_50  in  1  clock
- Resetn  in  1  synchronous, active-low reset
- init  in  1  load head to (X0,Y0); accepted only in IDLE
- start  in  1  leave IDLE (level)
- tick  in  1  frame pace strobe, one cycle
- dir_valid  in  1  latch dir this cycle
- dir  in  2  00 right, 01 down, 10 up, 11 left
- tgt_load  in  1  load tgt_x/tgt_y; accepted only in IDLE or WAIT
- tgt_x  in  8  target x
- tgt_y  in  7  target y
- head_colour  in  3  head colour
- tgt_colour  in  3  target colour
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  high in every state except IDLE and WAIT
- hit  out  1  one-cycle pulse on overlap
- head_x  out  8  current head x
- head_y  out  7  current head y

## Operation
- States: IDLE, DRAW_HEAD, DRAW_TGT, WAIT, ERASE, MOVE.
- IDLE: go to DRAW_HEAD on `start`.
- DRAW_HEAD, DRAW_TGT, ERASE: raster scan of the box.
  - xc counts 0..XDIM-1; yc increments when xc wraps.
  - Pixel = (base_x+xc, base_y+yc), one pixel per cycle, XDIM*YDIM cycles per state.
  - Counters are cleared on entry to each state.
- DRAW_HEAD uses head position and head_colour, then goes to DRAW_TGT.
- DRAW_TGT uses target position and tgt_colour, then goes to WAIT.
- WAIT: plot=0; on `tick` go to ERASE.
- ERASE: scans the head box with BG_COLOUR, then goes to MOVE.
- MOVE: one cycle, then DRAW_HEAD.
  - Head is updated by the latched direction only if the `moving` flag is set.
  - `moving` resets to 0 and is set by the first dir_valid.
- Direction register: reset 00. Any dir_valid in any state loads `dir`; the value in use is the one latched at MOVE.
- Stop mode (EDGE_MODE=0), x axis:
  - Right: x = min(x+STEP, XSCREEN-XDIM).
  - Left: x = max(x-STEP, 0).
  - y axis is the same with YSCREEN/YDIM.
  - Arithmetic uses 9-bit x and 8-bit y to avoid overflow.
- Wrap mode (EDGE_MODE=1):
  - Right past XSCREEN-XDIM gives 0.
  - Left below 0 gives XSCREEN-XDIM.
  - y axis is the same.
- hit: asserted the cycle after MOVE (first DRAW_HEAD cycle) if the new head box overlaps the target box.
  - Overlap test, both must hold: |hx-tx| < XDIM and |hy-ty| < YDIM.
  - Both boxes are XDIM x YDIM.
- Target register: reset (80,60). A tgt_load accepted in WAIT takes effect at the next DRAW_TGT; the old target is not erased by this block.
- init outside IDLE is ignored.

## Timing
- Reset: state IDLE, head=(0,0), target=(80,60), dir=00, moving=0, counters 0.
- Outputs in reset: plot=0, hit=0, busy=0, vga_x=0, vga_y=0, vga_colour=0.
- init in IDLE: head=(X0,Y0) the next cycle.
- vga_x, vga_y, vga_colour and plot are combinational from state and counters, valid in the same cycle.
- plot is high exactly XDIM*YDIM cycles in each draw and erase state; no gap cycles inside a state.
- One frame, tick to next WAIT: 2*XDIM*YDIM + XDIM*YDIM + 1 cycles.
  - That is ERASE (XDIM*YDIM) + MOVE (1) + DRAW_HEAD + DRAW_TGT (2*XDIM*YDIM).
- tick outside WAIT is ignored; ticks are not queued.
- dir_valid in the same cycle as MOVE: the new dir is not used in that MOVE.
- Resetn low mid-scan: IDLE next cycle, plot=0 immediately after the reset edge. Pixels already written stay on screen.
- Simultaneous tgt_load and tick in WAIT: the target loads, and ERASE starts.

## Test plan
- Reset, init, start, XDIM=YDIM=10 -> 100 plot cycles at (39..48, 59..68) in head_colour, then 100 at (80..89, 60..69), then WAIT, busy=0.
- dir_valid dir=00, one tick -> ERASE of 100 pixels in BG_COLOUR at the old box, head_x=40 after MOVE, redraw starts at x=40.
- EDGE_MODE=0, head (150,59), dir=00 -> head_x stays 150 for repeated ticks.
- EDGE_MODE=1, head (0,59), dir=11 -> head_x=150. Head (150,59), dir=00 -> head_x=0.
- Target (45,59), head (35,59), dir right, STEP=1 -> hit pulse exactly 1 cycle on the first overlapping frame (head_x=36), and again on each later overlapping frame.
- Resetn low during DRAW_TGT pixel 37 -> next cycle IDLE, plot=0, head=(0,0); tick ignored until start.
